// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by the target receiver and the master transmitter.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_DATA,
        ST_ACK_DATA,
        ST_IGNORE
    } i2c_state_t;

    // Header byte is {addr[6:0], rw}; a hit is our address with rw = write.
    function automatic logic addr_hit(input logic [I2C_DATA_W-1:0] hdr,
                                      input logic [I2C_ADDR_W-1:0] own);
        return (hdr[I2C_DATA_W-1:1] == own) && !hdr[0];
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for one raw bus line plus a history flop for
// rise/fall detection. Resets to 1 because an idle I2C line is pulled high.
module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain and one-cycle history for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_target_rx.sv
// Receive-only I2C target: START/STOP detect, address match, ACK drive and
// byte delivery as a one-cycle strobe.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | bus free, waiting for START
// ST_ADDR      | shifting the 7-bit address and RW bit
// ST_ACK_ADDR  | address matched (write); drive ACK for the 9th bit
// ST_DATA      | shifting a data byte
// ST_ACK_DATA  | byte delivered; drive ACK for the 9th bit
// ST_IGNORE    | transfer not for us (or a read); wait for START/STOP
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] ADDR = 7'h50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_out,
    output logic                  sda_oe,
    output logic [I2C_DATA_W-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  addr_match,
    output logic                  busy
);

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;

    i2c_sync_edge u_sync_scl (
        .clk  (clk),
        .rst  (rst),
        .raw  (scl_in),
        .sync (scl_s),
        .rise (scl_rise),
        .fall (scl_fall)
    );

    i2c_sync_edge u_sync_sda (
        .clk  (clk),
        .rst  (rst),
        .raw  (sda_in),
        .sync (sda_s),
        .rise (sda_rise),
        .fall (sda_fall)
    );

    logic start_cond;
    logic stop_cond;

    assign start_cond = sda_fall & scl_s;
    assign stop_cond  = sda_rise & scl_s;

    i2c_state_t            state_q, state_n;
    logic [2:0]            cnt_q, cnt_n;
    logic [I2C_DATA_W-1:0] shift_q, shift_n;
    logic                  drv_q, drv_n;
    logic [I2C_DATA_W-1:0] data_n;
    logic                  valid_n;
    logic                  match_n;
    logic                  busy_n;

    // Next-state, shifter, counter and ACK-drive decisions.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        shift_n = shift_q;
        drv_n   = drv_q;
        data_n  = rd_data;
        valid_n = 1'b0;
        match_n = addr_match;
        busy_n  = busy;

        if (start_cond) begin
            // Also covers repeated START; any partial byte is dropped.
            state_n = ST_ADDR;
            cnt_n   = '0;
            drv_n   = 1'b0;
            match_n = 1'b0;
            busy_n  = 1'b1;
        end else if (stop_cond) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            drv_n   = 1'b0;
            match_n = 1'b0;
            busy_n  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end

                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_n = {shift_q[I2C_DATA_W-2:0], sda_s};
                        if (cnt_q == 3'd7) begin
                            cnt_n = '0;
                            if (addr_hit(shift_n, ADDR)) begin
                                state_n = ST_ACK_ADDR;
                                match_n = 1'b1;
                            end else begin
                                state_n = ST_IGNORE;
                            end
                        end else begin
                            cnt_n = cnt_q + 3'd1;
                        end
                    end
                end

                ST_ACK_ADDR, ST_ACK_DATA: begin
                    // First fall: 9th bit begins, pull low. Second fall: release.
                    if (scl_fall) begin
                        if (!drv_q) begin
                            drv_n = 1'b1;
                        end else begin
                            drv_n   = 1'b0;
                            state_n = ST_DATA;
                            cnt_n   = '0;
                        end
                    end
                end

                ST_DATA: begin
                    if (scl_rise) begin
                        shift_n = {shift_q[I2C_DATA_W-2:0], sda_s};
                        if (cnt_q == 3'd7) begin
                            cnt_n   = '0;
                            data_n  = shift_n;
                            valid_n = 1'b1;
                            state_n = ST_ACK_DATA;
                        end else begin
                            cnt_n = cnt_q + 3'd1;
                        end
                    end
                end

                ST_IGNORE: begin
                end

                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    drv_n   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; the pad drive follows drv_q one cycle later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            drv_q      <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            addr_match <= 1'b0;
            busy       <= 1'b0;
            sda_oe     <= 1'b0;
            sda_out    <= 1'b1;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            shift_q    <= shift_n;
            drv_q      <= drv_n;
            rd_data    <= data_n;
            rd_valid   <= valid_n;
            addr_match <= match_n;
            busy       <= busy_n;
            sda_oe     <= drv_q;
            sda_out    <= ~drv_q;
        end
    end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: an I2C master model drives SCL/SDA on a wired-AND
// line with the target's open-drain output.
module tb_i2c_target_rx;

    localparam int H = 10;   // SCL half period in clk cycles
    localparam int Q = 3;    // SDA change point inside SCL low

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl_in = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_in;
    logic       sda_out, sda_oe, rd_valid, addr_match, busy;
    logic [7:0] rd_data;

    assign sda_in = sda_m & ~(sda_oe & ~sda_out);

    i2c_target_rx dut (
        .clk        (clk),
        .rst        (rst),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .sda_out    (sda_out),
        .sda_oe     (sda_oe),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .addr_match (addr_match),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor, sampled on the falling clk edge.
    logic [7:0] got_q[$];
    logic       oe_seen = 1'b0;
    logic       prev_oe = 1'b0;
    logic       prev_match = 1'b0;
    int         valid_cyc = 0, oe_on_cyc = 0, oe_off_cyc = 0, match_off_cyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (rd_valid) begin
                got_q.push_back(rd_data);
                valid_cyc = cyc;
            end
            if (sda_oe) oe_seen = 1'b1;
            if (sda_oe && !prev_oe) oe_on_cyc = cyc;
            if (!sda_oe && prev_oe) oe_off_cyc = cyc;
            if (!addr_match && prev_match) match_off_cyc = cyc;
        end
        prev_oe    = sda_oe;
        prev_match = addr_match;
    end

    // Master model.
    int last_rise_cyc = 0, last_fall_cyc = 0, start_sda_cyc = 0;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start;
        if (!scl_in) begin
            wait_clk(Q); sda_m = 1'b1;
            wait_clk(H - Q); scl_in = 1'b1; last_rise_cyc = cyc;
        end
        wait_clk(H / 2); sda_m = 1'b0; start_sda_cyc = cyc;
        wait_clk(H / 2); scl_in = 1'b0; last_fall_cyc = cyc;
    endtask

    task automatic send_bit(input logic b);
        wait_clk(Q); sda_m = b;
        wait_clk(H - Q); scl_in = 1'b1; last_rise_cyc = cyc;
        wait_clk(H); scl_in = 1'b0; last_fall_cyc = cyc;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic ack_bit(output logic acked);
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(H - Q); scl_in = 1'b1; last_rise_cyc = cyc;
        wait_clk(H / 2); acked = !sda_in;
        wait_clk(H / 2); scl_in = 1'b0; last_fall_cyc = cyc;
    endtask

    task automatic do_stop;
        wait_clk(Q); sda_m = 1'b0;
        wait_clk(H - Q); scl_in = 1'b1; last_rise_cyc = cyc;
        wait_clk(H / 2); sda_m = 1'b1;
        wait_clk(H);
    endtask

    task automatic run_xfer(input logic [6:0] a, input logic rw, input int nb,
                            input logic [23:0] dv, output logic aack,
                            output int dacks, output logic mm);
        logic ak;
        do_start;
        send_byte({a, rw});
        ack_bit(aack);
        mm = addr_match;
        dacks = 0;
        for (int i = 0; i < nb; i++) begin
            send_byte(dv[8*i +: 8]);
            ack_bit(ak);
            if (ak) dacks++;
        end
        do_stop;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_match"}, int'(addr_match), 0);
        check({tag, "_oe"}, int'(sda_oe), 0);
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        int          nb;
        logic [23:0] dv;
        logic        exp_ack;
        int          exp_nv;
        logic [23:0] exp_dv;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic       aack, mm, ak;
        int         dacks, fall8, rise8, ack_fall, budget;
        logic [7:0] model_last;
        logic [7:0] exp_q[$];

        vecs[0] = '{7'h50, 1'b0, 1, 24'h0000AA, 1'b1, 1, 24'h0000AA};
        vecs[1] = '{7'h51, 1'b0, 1, 24'h0000AA, 1'b0, 0, 24'h000000};
        vecs[2] = '{7'h50, 1'b1, 1, 24'h0000AA, 1'b0, 0, 24'h000000};
        vecs[3] = '{7'h50, 1'b0, 2, 24'h003412, 1'b1, 2, 24'h003412};
        vecs[4] = '{7'h28, 1'b0, 1, 24'h000055, 1'b0, 0, 24'h000000};
        vecs[5] = '{7'h50, 1'b0, 3, 24'h5AFF00, 1'b1, 3, 24'h5AFF00};
        vecs[6] = '{7'h10, 1'b0, 2, 24'h00A5C3, 1'b0, 0, 24'h000000};
        vecs[7] = '{7'h50, 1'b0, 1, 24'h000001, 1'b1, 1, 24'h000001};

        // Reset values.
        wait_clk(4);
        check("rst_sda_out", int'(sda_out), 1);
        check("rst_sda_oe", int'(sda_oe), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_match", int'(addr_match), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b1;
        wait_clk(5);

        // Single byte with latency checks.
        got_q.delete();
        do_start;
        check("s1_busy", int'(busy), 1);
        send_byte(8'hA0);
        ack_bit(aack);
        check("s1_addr_ack", int'(aack), 1);
        check("s1_match", int'(addr_match), 1);
        send_byte(8'hAA);
        rise8 = last_rise_cyc;
        fall8 = last_fall_cyc;
        check("s1_valid_lat", valid_cyc - rise8, 3);
        ack_bit(aack);
        ack_fall = last_fall_cyc;
        check("s1_data_ack", int'(aack), 1);
        check("s1_ack_on_lat", oe_on_cyc - fall8, 4);
        do_stop;
        check("s1_ack_off_lat", oe_off_cyc - ack_fall, 4);
        check("s1_nvalid", got_q.size(), 1);
        check("s1_rd_data", int'(rd_data), 8'hAA);
        check_idle("s1");

        // Table-driven transfers.
        foreach (vecs[k]) begin
            got_q.delete();
            oe_seen = 1'b0;
            run_xfer(vecs[k].addr, vecs[k].rw, vecs[k].nb, vecs[k].dv, aack, dacks, mm);
            check($sformatf("v%0d_addr_ack", k), int'(aack), int'(vecs[k].exp_ack));
            check($sformatf("v%0d_match", k), int'(mm), int'(vecs[k].exp_ack));
            check($sformatf("v%0d_data_acks", k), dacks, vecs[k].exp_nv);
            check($sformatf("v%0d_oe_seen", k), int'(oe_seen), int'(vecs[k].exp_ack));
            check($sformatf("v%0d_nvalid", k), got_q.size(), vecs[k].exp_nv);
            for (int j = 0; j < vecs[k].exp_nv && j < got_q.size(); j++)
                check($sformatf("v%0d_byte%0d", k, j), int'(got_q[j]),
                      int'(vecs[k].exp_dv[8*j +: 8]));
            check_idle($sformatf("v%0d", k));
        end

        // Two bytes, repeated START, third byte.
        got_q.delete();
        do_start;
        send_byte(8'hA0); ack_bit(ak);
        send_byte(8'h12); ack_bit(ak);
        send_byte(8'h34); ack_bit(ak);
        check("rs_match_before", int'(addr_match), 1);
        do_start;
        check("rs_match_drop_lat", match_off_cyc - start_sda_cyc, 3);
        check("rs_match_after", int'(addr_match), 0);
        check("rs_busy", int'(busy), 1);
        send_byte(8'hA0); ack_bit(aack);
        check("rs_addr_ack", int'(aack), 1);
        send_byte(8'h56); ack_bit(ak);
        do_stop;
        check("rs_nvalid", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("rs_b0", int'(got_q[0]), 8'h12);
            check("rs_b1", int'(got_q[1]), 8'h34);
            check("rs_b2", int'(got_q[2]), 8'h56);
        end
        check_idle("rs");

        // STOP in the middle of a data byte.
        got_q.delete();
        do_start;
        send_byte(8'hA0); ack_bit(ak);
        send_byte(8'h77); ack_bit(ak);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        do_stop;
        check("ps_nvalid", got_q.size(), 1);
        check("ps_rd_data", int'(rd_data), 8'h77);
        check_idle("ps");

        // Reset while the ACK is being driven.
        do_start;
        send_byte(8'hA0); ack_bit(ak);
        send_byte(8'h99);
        budget = 20;
        while (!sda_oe && budget > 0) begin
            wait_clk(1);
            budget--;
        end
        check("rr_oe_before", int'(sda_oe), 1);
        rst = 1'b0;
        wait_clk(1);
        check("rr_oe", int'(sda_oe), 0);
        check("rr_sda_out", int'(sda_out), 1);
        check("rr_rd_data", int'(rd_data), 0);
        check("rr_busy", int'(busy), 0);
        check("rr_match", int'(addr_match), 0);
        wait_clk(2);
        rst = 1'b1;
        do_stop;
        got_q.delete();
        run_xfer(7'h50, 1'b0, 1, 24'h0000C3, aack, dacks, mm);
        check("rr_addr_ack", int'(aack), 1);
        check("rr_nvalid", got_q.size(), 1);
        check("rr_rd_data_c3", int'(rd_data), 8'hC3);
        model_last = 8'hC3;

        // Randomized transfers against the protocol-level model.
        for (int t = 0; t < 20; t++) begin
            logic [6:0]  a;
            logic        rw, acked;
            int          nb;
            logic [23:0] dv;
            a  = ($urandom_range(0, 1) == 1) ? 7'h50 : 7'($urandom_range(0, 127));
            rw = ($urandom_range(0, 3) == 0);
            nb = $urandom_range(1, 3);
            dv = 24'($urandom);
            acked = (a == 7'h50) && !rw;
            exp_q.delete();
            if (acked) begin
                for (int j = 0; j < nb; j++) exp_q.push_back(dv[8*j +: 8]);
                model_last = exp_q[nb-1];
            end
            got_q.delete();
            oe_seen = 1'b0;
            run_xfer(a, rw, nb, dv, aack, dacks, mm);
            check($sformatf("r%0d_addr_ack", t), int'(aack), int'(acked));
            check($sformatf("r%0d_data_acks", t), dacks, exp_q.size());
            check($sformatf("r%0d_oe_seen", t), int'(oe_seen), int'(acked));
            check($sformatf("r%0d_nvalid", t), got_q.size(), exp_q.size());
            for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
                check($sformatf("r%0d_byte%0d", t, j), int'(got_q[j]), int'(exp_q[j]));
            check($sformatf("r%0d_rd_data", t), int'(rd_data), int'(model_last));
            check_idle($sformatf("r%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
